led_pattern_ctrl: RTL and testbench



---
 rtl/led_pattern_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer for the 8 green LEDs.
// It divides CLOCK_50 down to a step tick and plays one of four shift patterns.
// A newly loaded pattern is held pending and swapped in only at a frame boundary.
module led_pattern_ctrl #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic       mode_load,
  input  logic [1:0] speed,
  output logic [7:0] LEDR,
  output logic       tick,
  output logic       frame_done,
  output logic [1:0] cur_mode,
  output logic       pending
);

  // DIV must be >= 8 and a multiple of 8 so that DIV >> 3 is a whole, non-zero period.
  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW = $clog2(Div);

  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [2:0]      step;
  logic [1:0]      pend_mode;

  logic [31:0]     period_m1;
  logic            step_fire;
  logic            step_wrap;
  logic [1:0]      start_mode;

  // LED pattern for a given mode and step index.
  function automatic logic [7:0] pattern(input logic [1:0] m, input logic [2:0] s);
    logic [7:0] p;
    logic [1:0] idx;
    p   = 8'h00;
    idx = 2'd0;
    unique case (m)
      2'd0: begin
        // Outside-to-middle: two LEDs converging.
        idx = s[1:0];
        p   = (8'h80 >> idx) | (8'h01 << idx);
      end
      2'd1: begin
        // Middle-to-outside: the same walk played backwards.
        idx = 2'd3 - s[1:0];
        p   = (8'h80 >> idx) | (8'h01 << idx);
      end
      2'd2: p = 8'h01 << s;
      2'd3: p = 8'hFF >> (3'd7 - s);
    endcase
    return p;
  endfunction

  // Index of the final step in a frame for the given mode.
  function automatic logic [2:0] last_step(input logic [1:0] m);
    return m[1] ? 3'd7 : 3'd3;
  endfunction

  // Step-fire compare and frame-wrap detection.
  always_comb begin
    period_m1  = (Div >> speed) - 32'd1;
    // ">=" so a speed increase with cnt already past the new limit fires at once.
    step_fire  = ({{(32-CntW){1'b0}}, cnt} >= period_m1);
    step_wrap  = (step == last_step(cur_mode));
    start_mode = pending ? pend_mode : cur_mode;
  end

  // Sequencer state, divider, step index and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      step       <= 3'd0;
      pend_mode  <= 2'd0;
      LEDR       <= 8'h00;
      tick       <= 1'b0;
      frame_done <= 1'b0;
      cur_mode   <= 2'd0;
      pending    <= 1'b0;
    end else begin
      tick       <= 1'b0;
      frame_done <= 1'b0;

      unique case (state)
        StIdle: begin
          LEDR <= 8'h00;
          cnt  <= '0;
          if (pending) begin
            cur_mode <= pend_mode;
            pending  <= 1'b0;
          end
          if (run) begin
            state      <= StRun;
            step       <= 3'd0;
            LEDR       <= pattern(start_mode, 3'd0);
            tick       <= 1'b1;
            frame_done <= 1'b1;
          end
        end

        // A cycle with run=1 counts whether it started in RUN or PAUSE, so a
        // resume continues from the held count without losing a cycle.
        StRun, StPause: begin
          if (!run) begin
            state <= StPause;
          end else begin
            state <= StRun;
            if (step_fire) begin
              cnt  <= '0;
              tick <= 1'b1;
              if (step_wrap) begin
                step       <= 3'd0;
                frame_done <= 1'b1;
                if (pending) begin
                  cur_mode <= pend_mode;
                  pending  <= 1'b0;
                  LEDR     <= pattern(pend_mode, 3'd0);
                end else begin
                  LEDR <= pattern(cur_mode, 3'd0);
                end
              end else begin
                step <= step + 3'd1;
                LEDR <= pattern(cur_mode, step + 3'd1);
              end
            end else begin
              cnt <= cnt + CntOne;
            end
          end
        end

        default: state <= StIdle;
      endcase

      // Placed last so a load on an application edge survives as the next pending mode.
      if (mode_load) begin
        pend_mode <= mode;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with DIV = 16.
module tb_led_pattern_ctrl;

  localparam int Div = 16;

  logic       clk;
  logic       reset;
  logic       run;
  logic [1:0] mode;
  logic       mode_load;
  logic [1:0] speed;
  logic [7:0] LEDR;
  logic       tick;
  logic       frame_done;
  logic [1:0] cur_mode;
  logic       pending;

  int checks = 0;
  int errors = 0;
  int n;

  led_pattern_ctrl #(
    .CLK_HZ (16),
    .TICK_HZ(1)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .run       (run),
    .mode      (mode),
    .mode_load (mode_load),
    .speed     (speed),
    .LEDR      (LEDR),
    .tick      (tick),
    .frame_done(frame_done),
    .cur_mode  (cur_mode),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: pattern tables written out literally, one update per clock.
  logic [7:0] tbl [4][8];
  int         flen [4];
  bit         m_valid = 1'b0;
  int         m_phase;   // 0 idle, 1 running, 2 paused
  int         m_elapsed;
  int         m_step;
  int         m_mode;
  int         m_pmode;
  bit         m_pend;
  logic [7:0] m_led;
  bit         m_tick;
  bit         m_fd;

  initial begin
    tbl[0] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    tbl[3] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    flen   = '{4, 4, 8, 8};
  end

  always @(posedge clk) begin
    if (reset) begin
      m_valid   = 1'b1;
      m_phase   = 0;
      m_elapsed = 0;
      m_step    = 0;
      m_mode    = 0;
      m_pmode   = 0;
      m_pend    = 1'b0;
      m_led     = 8'h00;
      m_tick    = 1'b0;
      m_fd      = 1'b0;
    end else if (m_valid) begin
      m_tick = 1'b0;
      m_fd   = 1'b0;
      if (m_phase == 0) begin
        m_led     = 8'h00;
        m_elapsed = 0;
        if (m_pend) begin
          m_mode = m_pmode;
          m_pend = 1'b0;
        end
        if (run) begin
          m_phase = 1;
          m_step  = 0;
          m_led   = tbl[m_mode][0];
          m_tick  = 1'b1;
          m_fd    = 1'b1;
        end
      end else if (!run) begin
        m_phase = 2;
      end else begin
        m_phase = 1;
        if (m_elapsed + 1 >= (Div >> speed)) begin
          m_elapsed = 0;
          m_tick    = 1'b1;
          m_step    = (m_step + 1) % flen[m_mode];
          if (m_step == 0) begin
            m_fd = 1'b1;
            if (m_pend) begin
              m_mode = m_pmode;
              m_pend = 1'b0;
            end
          end
          m_led = tbl[m_mode][m_step];
        end else begin
          m_elapsed++;
        end
      end
      if (mode_load) begin
        m_pmode = int'(mode);
        m_pend  = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_ledr", LEDR, m_led);
      chk("cmp_tick", tick, m_tick);
      chk("cmp_frame_done", frame_done, m_fd);
      chk("cmp_cur_mode", cur_mode, m_mode[1:0]);
      chk("cmp_pending", pending, m_pend);
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    mode      = 2'd0;
    mode_load = 1'b0;
    speed     = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (tick === 1'b1) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] oi_seq  [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h81};
  logic [7:0] bar_seq [8] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    mode      = 2'd0;
    mode_load = 1'b0;
    speed     = 2'd0;

    // OUT_IN default frame, 16-clock step period.
    do_reset();
    chk("rst_ledr", LEDR, 8'h00);
    chk("rst_tick", tick, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_cur_mode", cur_mode, 2'd0);
    chk("rst_pending", pending, 1'b0);
    run = 1'b1;
    wait_tick(40, n);
    chk("t1_first_latency", n, 1);
    chk("t1_ledr0", LEDR, 8'h81);
    chk("t1_fd0", frame_done, 1'b1);
    for (int i = 1; i < 5; i++) begin
      wait_tick(40, n);
      chk("t1_period", n, 16);
      chk("t1_ledr", LEDR, oi_seq[i]);
      chk("t1_fd", frame_done, (i == 4));
    end
    chk("t1_cur_mode", cur_mode, 2'd0);

    // ROTATE_L loaded in IDLE, then speed sweep.
    do_reset();
    mode      = 2'd2;
    mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
    chk("t2_pending_idle", pending, 1'b1);
    @(negedge clk);
    chk("t2_applied_mode", cur_mode, 2'd2);
    chk("t2_applied_pend", pending, 1'b0);
    run = 1'b1;
    wait_tick(40, n);
    chk("t2_led0", LEDR, 8'h01);
    wait_tick(40, n);
    chk("t2_speed0_period", n, 16);
    chk("t2_led1", LEDR, 8'h02);
    speed = 2'd3;
    wait_tick(40, n);
    chk("t2_speed3_period", n, 2);
    chk("t2_led2", LEDR, 8'h04);
    wait_tick(40, n);
    chk("t2_speed3_period_b", n, 2);
    chk("t2_led3", LEDR, 8'h08);
    speed = 2'd0;
    wait_tick(40, n);
    chk("t2_back_to_16", n, 16);
    chk("t2_led4", LEDR, 8'h10);
    repeat (10) @(negedge clk);
    speed = 2'd3;
    wait_tick(40, n);
    chk("t2_no_stall", n, 1);
    chk("t2_led5", LEDR, 8'h20);
    speed = 2'd0;

    // Mode change to BAR is deferred to the frame boundary.
    do_reset();
    run = 1'b1;
    wait_tick(40, n);
    wait_tick(40, n);
    chk("t3_ledr_42", LEDR, 8'h42);
    mode      = 2'd3;
    mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
    chk("t3_pending", pending, 1'b1);
    wait_tick(40, n);
    chk("t3_gap", n, 15);
    chk("t3_ledr_24", LEDR, 8'h24);
    wait_tick(40, n);
    chk("t3_ledr_18", LEDR, 8'h18);
    chk("t3_still_pending", pending, 1'b1);
    chk("t3_mode_held", cur_mode, 2'd0);
    wait_tick(40, n);
    chk("t3_bar_start", LEDR, 8'h01);
    chk("t3_bar_mode", cur_mode, 2'd3);
    chk("t3_bar_pend", pending, 1'b0);
    chk("t3_bar_fd", frame_done, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_tick(40, n);
      chk("t3_bar_ledr", LEDR, bar_seq[i]);
      chk("t3_bar_fd_step", frame_done, (i == 7));
    end

    // Pause at cnt=5 on the 24h step, resume.
    do_reset();
    run = 1'b1;
    repeat (3) wait_tick(40, n);
    chk("t4_ledr_24", LEDR, 8'h24);
    repeat (5) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("t4_hold_ledr", LEDR, 8'h24);
      chk("t4_hold_tick", tick, 1'b0);
    end
    run = 1'b1;
    wait_tick(40, n);
    chk("t4_resume_gap", n, 11);
    chk("t4_resume_ledr", LEDR, 8'h18);

    // Double load inside a frame; load coinciding with the application edge.
    do_reset();
    run = 1'b1;
    wait_tick(40, n);
    mode      = 2'd1;
    mode_load = 1'b1;
    @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    mode_load = 1'b0;
    repeat (3) wait_tick(40, n);
    chk("t5_ledr_18", LEDR, 8'h18);
    repeat (15) @(negedge clk);
    mode      = 2'd3;
    mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
    chk("t5_boundary_tick", tick, 1'b1);
    chk("t5_boundary_ledr", LEDR, 8'h01);
    chk("t5_last_wins", cur_mode, 2'd2);
    chk("t5_new_pending", pending, 1'b1);

    // Reset mid-RUN with a load pending.
    do_reset();
    run = 1'b1;
    repeat (3) wait_tick(40, n);
    mode      = 2'd3;
    mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
    chk("t6_pending", pending, 1'b1);
    chk("t6_ledr_24", LEDR, 8'h24);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_ledr", LEDR, 8'h00);
    chk("t6_rst_tick", tick, 1'b0);
    chk("t6_rst_mode", cur_mode, 2'd0);
    chk("t6_rst_pend", pending, 1'b0);
    @(negedge clk);
    chk("t6_restart_ledr", LEDR, 8'h81);
    chk("t6_restart_tick", tick, 1'b1);

    // Load coinciding with an IDLE application keeps the new load pending.
    do_reset();
    mode      = 2'd1;
    mode_load = 1'b1;
    @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    mode_load = 1'b0;
    chk("t7_old_applied", cur_mode, 2'd1);
    chk("t7_still_pending", pending, 1'b1);
    @(negedge clk);
    chk("t7_new_applied", cur_mode, 2'd3);
    chk("t7_cleared", pending, 1'b0);
    run = 1'b1;
    wait_tick(40, n);
    chk("t7_bar_start", LEDR, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
